serial_subtractor: RTL

Parametrised multi-cycle subtractor that computes `a - b - bin` on WIDTH-bit operands, SLICE bits per clock, LSB slice first, with a registered borrow between slices. It is the sequential, width-generalised successor of the 1-bit full subtractor (`flsub`). It serves datapaths where a single wide borrow chain is too slow or too large. A start/ready/done handshake drives it, and results are held until the next operation.

---
 rtl/serial_subtractor_pkg.sv | 32 +++
 rtl/serial_subtractor_sub_slice.sv | 28 ++
 rtl/serial_subtractor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the slice-serial subtractor.
// Holds the FSM state type, step-count math and the 1-bit flsub cell.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int steps(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic bit slice_ok(input int width, input int slice);
    return (width >= 1) && (slice >= 1) && ((width % slice) == 0);
  endfunction

  // {borrow_out, diff} of a - b - c
  function automatic logic [1:0] flsub(
    input logic a,
    input logic b,
    input logic c
  );
    logic d;
    logic bo;
    d  = a ^ b ^ c;
    bo = (~a & b) | (~a & c) | (b & c);
    return {bo, d};
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor.
// One flsub cell per bit, borrow rippling LSB to MSB.
module sub_slice
  import serial_subtractor_pkg::*;
#(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c,
  output logic [SLICE-1:0] d,
  output logic             bo
);

  logic [SLICE:0] br;

  assign br[0] = c;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    logic [1:0] r;
    assign r       = flsub(a[i], b[i], br[i]);
    assign d[i]    = r[0];
    assign br[i+1] = r[1];
  end

  assign bo = br[SLICE];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, SLICE bits per clock, LSB slice first.
// Borrow is carried between slices only through borrow_q.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int STEPS = steps(WIDTH, SLICE);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (!slice_ok(WIDTH, SLICE)) begin : g_bad_cfg
    $error("serial_subtractor: SLICE must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0]       d_slice;
  logic                   b_next;
  logic [WIDTH+SLICE-1:0] work_cat;
  logic                   last;

  sub_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a (a_q[SLICE-1:0]),
    .b (b_q[SLICE-1:0]),
    .c (borrow_q),
    .d (d_slice),
    .bo(b_next)
  );

  assign work_cat = {d_slice, work_q};
  assign last     = (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          count_d  = '0;
        end
      end
      RUN: begin
        a_d      = a_q >> SLICE;
        b_d      = b_q >> SLICE;
        work_d   = work_cat[WIDTH+SLICE-1:SLICE];
        borrow_d = b_next;
        count_d  = count_q + 1'b1;
        if (last) begin
          diff_d = work_d;
          bout_d = b_next;
          zero_d = (work_d == '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
    diff  = diff_q;
    bout  = bout_q;
    zero  = zero_q;
  end

endmodule
